// File: rtl/smps_pwm_sequencer.sv
// Single-phase SMPS PWM sequencer: period counter, dead-time gate compare,
// soft-start ramp and fault/disable shutdown.
module smps_pwm_sequencer #(
   parameter int N    = 10,
   parameter int DT_W = 4,
   parameter int SS_W = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_enable,
   input  logic            i_fault,
   input  logic            i_fault_clr,
   input  logic [N-1:0]    i_period,
   input  logic [N-1:0]    i_duty,
   input  logic [DT_W-1:0] i_deadtime,
   input  logic [SS_W-1:0] i_ss_div,
   output logic            o_hs,
   output logic            o_ls,
   output logic [1:0]      o_state,
   output logic [N-1:0]    o_cur_duty,
   output logic            o_period_start
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SS   = 2'd1,
      S_RUN  = 2'd2,
      S_FLT  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    cnt_q, cnt_d;
   logic [N-1:0]    cur_q, cur_d;
   logic [N-1:0]    per_q, per_d;
   logic [N-1:0]    duty_q, duty_d;
   logic [DT_W-1:0] dt_q, dt_d;
   logic [SS_W-1:0] ss_q, ss_d;
   logic            hs_q, hs_d;
   logic            ls_q, ls_d;

   logic [N-1:0]    p_eff;
   logic [N:0]      d_x, dt_x, cnt_x;
   logic            active, active_d, wrap;
   logic            hs_nx, ls_nx;

   assign p_eff  = (per_q < N'(2)) ? N'(2) : per_q;
   assign active = (state_q == S_SS) || (state_q == S_RUN);
   assign wrap   = active && (cnt_q == p_eff - N'(1));

   // Compare in N+1 bits so d+DT cannot wrap.
   assign cnt_x = {1'b0, cnt_q};
   assign dt_x  = (N+1)'(dt_q);
   assign d_x   = (cur_q < p_eff) ? {1'b0, cur_q} : {1'b0, p_eff};
   assign hs_nx = (cnt_x >= dt_x) && (cnt_x < d_x);
   assign ls_nx = (cnt_x >= d_x + dt_x) && (cnt_q < p_eff);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cur_d   = cur_q;
      ss_d    = ss_q;
      per_d   = per_q;
      duty_d  = duty_q;
      dt_d    = dt_q;

      if ((state_q == S_IDLE) || wrap) begin
         per_d  = i_period;
         duty_d = i_duty;
         dt_d   = i_deadtime;
      end

      if (active) begin
         cnt_d = wrap ? '0 : cnt_q + N'(1);
      end

      unique case (state_q)
         S_IDLE: begin
            if (i_enable) state_d = S_SS;
         end
         S_SS: begin
            if (!i_enable) begin
               state_d = S_IDLE;
            end else if (wrap) begin
               if (ss_q == i_ss_div) begin
                  cur_d = cur_q + N'(1);
                  ss_d  = '0;
               end else begin
                  ss_d  = ss_q + SS_W'(1);
               end
               if (cur_d >= duty_q) state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (!i_enable) state_d = S_IDLE;
            else if (wrap) cur_d = duty_d;
         end
         S_FLT: begin
            if (i_fault_clr) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (i_fault) state_d = S_FLT;

      if ((state_d == S_IDLE) || (state_d == S_FLT)) begin
         cnt_d = '0;
         cur_d = '0;
         ss_d  = '0;
      end

      // Gates drop on the same edge the FSM leaves the switching states.
      active_d = (state_d == S_SS) || (state_d == S_RUN);
      hs_d     = active && active_d && hs_nx;
      ls_d     = active && active_d && ls_nx;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         cur_q   <= '0;
         ss_q    <= '0;
         hs_q    <= 1'b0;
         ls_q    <= 1'b0;
         per_q   <= i_period;
         duty_q  <= i_duty;
         dt_q    <= i_deadtime;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cur_q   <= cur_d;
         ss_q    <= ss_d;
         hs_q    <= hs_d;
         ls_q    <= ls_d;
         per_q   <= per_d;
         duty_q  <= duty_d;
         dt_q    <= dt_d;
      end
   end

   assign o_hs           = hs_q;
   assign o_ls           = ls_q;
   assign o_state        = state_q;
   assign o_cur_duty     = cur_q;
   assign o_period_start = active && (cnt_q == '0);

endmodule

// File: tb/tb_smps_pwm_sequencer.sv
// Bench for smps_pwm_sequencer: directed scenarios then random traffic,
// all cycles checked against a sequential reference model.
module tb_smps_pwm_sequencer;

   logic       clk;
   logic       reset;
   logic       i_enable;
   logic       i_fault;
   logic       i_fault_clr;
   logic [9:0] i_period;
   logic [9:0] i_duty;
   logic [3:0] i_deadtime;
   logic [7:0] i_ss_div;
   logic       o_hs;
   logic       o_ls;
   logic [1:0] o_state;
   logic [9:0] o_cur_duty;
   logic       o_period_start;

   int nvec = 0;
   int nerr = 0;

   int mst, mcnt, mcur, mss, mper, mduty, mdt, mhs, mls, mps;

   smps_pwm_sequencer dut (
      .clk            (clk),
      .reset          (reset),
      .i_enable       (i_enable),
      .i_fault        (i_fault),
      .i_fault_clr    (i_fault_clr),
      .i_period       (i_period),
      .i_duty         (i_duty),
      .i_deadtime     (i_deadtime),
      .i_ss_div       (i_ss_div),
      .o_hs           (o_hs),
      .o_ls           (o_ls),
      .o_state        (o_state),
      .o_cur_duty     (o_cur_duty),
      .o_period_start (o_period_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: advance the model with the inputs seen at the edge, then check.
   task automatic cyc();
      int p, d, nst, ncur, nss, ncnt;
      bit run, wrap, hsn, lsn;
      @(posedge clk);
      if (!reset) begin
         mst = 0; mcnt = 0; mcur = 0; mss = 0; mhs = 0; mls = 0;
         mper = i_period; mduty = i_duty; mdt = i_deadtime;
      end else begin
         p    = (mper < 2) ? 2 : mper;
         run  = (mst == 1) || (mst == 2);
         wrap = run && (mcnt == p - 1);
         d    = (mcur < p) ? mcur : p;
         hsn  = run && (mcnt >= mdt) && (mcnt < d);
         lsn  = run && (mcnt >= d + mdt) && (mcnt < p);
         nst  = mst; ncur = mcur; nss = mss;
         ncnt = run ? (wrap ? 0 : mcnt + 1) : 0;
         if (i_fault) nst = 3;
         else if (mst == 3) begin
            if (i_fault_clr) nst = 0;
         end else if (mst == 0) begin
            if (i_enable) nst = 1;
         end else if (!i_enable) nst = 0;
         else if (wrap && mst == 1) begin
            if (mss == i_ss_div) begin
               ncur = mcur + 1; nss = 0;
            end else nss = (mss + 1) % 256;
            if (ncur >= mduty) nst = 2;
         end else if (wrap && mst == 2) ncur = i_duty;
         if (nst == 0 || nst == 3) begin
            ncnt = 0; ncur = 0; nss = 0;
         end
         if (mst == 0 || wrap) begin
            mper = i_period; mduty = i_duty; mdt = i_deadtime;
         end
         mhs = (hsn && (nst == 1 || nst == 2)) ? 1 : 0;
         mls = (lsn && (nst == 1 || nst == 2)) ? 1 : 0;
         mst = nst; mcnt = ncnt; mcur = ncur; mss = nss;
      end
      mps = ((mst == 1 || mst == 2) && mcnt == 0) ? 1 : 0;
      #1;
      check("hs", o_hs, mhs);
      check("ls", o_ls, mls);
      check("state", o_state, mst);
      check("cur_duty", o_cur_duty, mcur);
      check("period_start", o_period_start, mps);
      check("no_overlap", o_hs && o_ls, 0);
   endtask

   task automatic next_ps(input string tag);
      cyc();
      for (int k = 0; k < 64 && o_period_start !== 1'b1; k++) cyc();
      check(tag, o_period_start, 1);
   endtask

   // Counts over one period starting at a period_start sample.
   task automatic window(output int h, output int l, output int ps);
      h = 0; l = 0; ps = 0;
      for (int k = 0; k < 10; k++) begin
         h += int'(o_hs); l += int'(o_ls); ps += int'(o_period_start);
         cyc();
      end
   endtask

   initial begin
      int h, l, ps;
      int exp_cur[7];
      exp_cur = '{0, 0, 1, 1, 2, 2, 3};

      reset = 1'b0; i_enable = 1'b0; i_fault = 1'b0; i_fault_clr = 1'b0;
      i_period = 10'd10; i_duty = 10'd3; i_deadtime = 4'd1; i_ss_div = 8'd1;
      cyc(); cyc();
      check("reset_state", o_state, 0);
      check("reset_gates", {o_hs, o_ls, o_period_start}, 0);

      // Soft-start ramp, one duty step every two periods.
      reset = 1'b1; i_enable = 1'b1;
      cyc();
      for (int j = 0; j < 7; j++) begin
         if (j > 0) next_ps("ss_ps");
         check("ss_ramp", o_cur_duty, exp_cur[j]);
         check("ss_state", o_state, (j < 6) ? 1 : 2);
      end

      // Gate timing with P=10, duty=6, DT=1.
      i_duty = 10'd6; i_ss_div = 8'd0;
      next_ps("t1_ps"); next_ps("t1_ps"); next_ps("t1_ps");
      window(h, l, ps);
      check("t1_hs_clks", h, 5);
      check("t1_ls_clks", l, 3);
      check("t1_ps_count", ps, 1);

      // Mid-period duty change is deferred to the next period.
      for (int k = 0; k < 30 && mcnt != 4; k++) cyc();
      i_duty = 10'd2;
      h = int'(o_hs);
      for (int k = 0; k < 20; k++) begin
         cyc();
         if (o_period_start === 1'b1) break;
         h += int'(o_hs);
      end
      check("t3_old_period_hs", h, 3);
      window(h, l, ps);
      check("t3_new_period_hs", h, 1);

      // Saturation at both ends.
      i_duty = 10'd12; i_deadtime = 4'd2;
      next_ps("t4_ps"); next_ps("t4_ps");
      window(h, l, ps);
      check("t4_sat_hs", h, 8);
      check("t4_sat_ls", l, 0);
      i_duty = 10'd2;
      next_ps("t4_ps"); next_ps("t4_ps");
      window(h, l, ps);
      check("t4_min_hs", h, 0);

      // Fault handling.
      i_duty = 10'd6; i_deadtime = 4'd1;
      next_ps("t5_ps"); next_ps("t5_ps");
      for (int k = 0; k < 30 && !(o_hs === 1'b1 && mcnt == 3); k++) cyc();
      check("t5_hs_before", o_hs, 1);
      i_fault = 1'b1; cyc(); i_fault = 1'b0;
      check("t5_hs_off", o_hs, 0);
      check("t5_state_flt", o_state, 3);
      cyc(); cyc(); cyc();
      check("t5_held", o_state, 3);
      i_fault = 1'b1; i_fault_clr = 1'b1; cyc();
      check("t5_clr_with_fault", o_state, 3);
      i_fault = 1'b0; i_fault_clr = 1'b0; cyc();
      check("t5_still_flt", o_state, 3);
      i_fault_clr = 1'b1; cyc(); i_fault_clr = 1'b0;
      check("t5_to_idle", o_state, 0);
      cyc();
      check("t5_restart", o_state, 1);
      check("t5_restart_duty", o_cur_duty, 0);

      // Reset in the middle of RUN.
      for (int k = 0; k < 200 && o_state !== 2'd2; k++) cyc();
      check("t6_run", o_state, 2);
      for (int k = 0; k < 30 && mcnt != 5; k++) cyc();
      reset = 1'b0; cyc(); reset = 1'b1;
      check("t6_state", o_state, 0);
      check("t6_outs", {o_hs, o_ls, o_period_start, o_cur_duty}, 0);

      // Random traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 39) == 0) i_duty = 10'($urandom_range(0, 25));
         if ($urandom_range(0, 59) == 0) i_period = 10'($urandom_range(0, 20));
         if ($urandom_range(0, 59) == 0) i_deadtime = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 199) == 0) i_ss_div = 8'($urandom_range(0, 3));
         if ($urandom_range(0, 149) == 0) i_enable = ~i_enable;
         i_fault     = ($urandom_range(0, 399) == 0);
         i_fault_clr = ($urandom_range(0, 19) == 0);
         reset       = ($urandom_range(0, 999) != 0);
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
